// File: rtl/register_file_param_if.sv
// Register-file access bundle: one write port, NUM_RD packed read ports,
// and the bulk-clear request/busy pair. The master drives requests and the
// slave (the register file) returns ready, read data and busy.
interface register_file_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) ();
  logic                       we;
  logic [ADDR_W-1:0]          waddr;
  logic [DATA_W-1:0]          wdata;
  logic                       wr_rdy;
  logic [NUM_RD*ADDR_W-1:0]   raddr;
  logic [NUM_RD*DATA_W-1:0]   rdata;
  logic                       clr_req;
  logic                       busy;

  modport master (
    output we, waddr, wdata, raddr, clr_req,
    input  wr_rdy, rdata, busy
  );

  modport slave (
    input  we, waddr, wdata, raddr, clr_req,
    output wr_rdy, rdata, busy
  );
endinterface

// File: rtl/register_file_param.sv
// Parametrised integer register file with NUM_RD combinational read ports,
// optional hardwired-zero entry 0 and a sequential bulk-clear sweep.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a write that
// commits this cycle is forwarded to any read port addressing the same
// entry; when undefined, reads show the pre-write value until the edge.
module register_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  register_file_param_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  // ptr is one bit wider than an address so the terminal compare cannot alias
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t             state;
  logic [ADDR_W:0]    ptr;
  logic               busy_reg;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               wr_rdy;
  logic               commit;
  logic               wr_keep;

  // Writes are accepted only outside reset and outside the clear sweep
  assign wr_rdy  = rst_n && !busy_reg;
  assign commit  = bus.we && wr_rdy;
  // A committed write to entry 0 is silently dropped when it is hardwired
  assign wr_keep = commit && !((ZERO_REG != 0) && (bus.waddr == '0));

  assign bus.wr_rdy = wr_rdy;
  assign bus.busy   = busy_reg;

  // Control FSM: IDLE accepts writes, CLEAR sweeps ptr over every entry once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      busy_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state    <= CLEAR;
            ptr      <= '0;
            busy_reg <= 1'b1;
          end
        end
        CLEAR: begin
          // clr_req is ignored here so a second pulse cannot stretch the sweep
          ptr <= ptr + 1'b1;
          if (ptr == LAST_PTR) begin
            state    <= IDLE;
            busy_reg <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          busy_reg <= 1'b0;
        end
      endcase
    end
  end

  // Storage: async zero on reset, sweep zeroing in CLEAR, normal writes in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == CLEAR) begin
      mem[ptr[ADDR_W-1:0]] <= '0;
    end else if (wr_keep) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  // Independent read ports, each with zero-register and busy gating on top
  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;

      assign ra = bus.raddr[gi*ADDR_W +: ADDR_W];

      // Priority: busy, then hardwired zero, then bypass, then stored value
      always_comb begin
        rd = mem[ra];
`ifdef REGFILE_BYPASS_EN
        if (commit && (ra == bus.waddr)) begin
          rd = bus.wdata;
        end
`endif
        if ((ZERO_REG != 0) && (ra == '0)) begin
          rd = '0;
        end
        if (busy_reg) begin
          rd = '0;
        end
      end

      assign bus.rdata[gi*DATA_W +: DATA_W] = rd;
    end
  endgenerate
endmodule

// File: tb/tb_register_file_param.sv
// Self-checking bench for register_file_param. Two instances run in lockstep
// on the same stimulus: one with ZERO_REG=1 and one with ZERO_REG=0.
// Honours REGFILE_BYPASS_EN in its expectations.
module tb_register_file_param;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          we = 1'b0;
  logic          clr_req = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [AW-1:0] ra0 = '0;
  logic [AW-1:0] ra1 = '0;

  register_file_param_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus1 ();
  register_file_param_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus0 ();

  assign bus1.we = we;      assign bus0.we = we;
  assign bus1.waddr = waddr; assign bus0.waddr = waddr;
  assign bus1.wdata = wdata; assign bus0.wdata = wdata;
  assign bus1.clr_req = clr_req; assign bus0.clr_req = clr_req;
  assign bus1.raddr = {ra1, ra0}; assign bus0.raddr = {ra1, ra0};

  register_file_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  register_file_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));

  int total = 0;
  int bad = 0;

  // Reference model: architectural contents and remaining busy cycles.
  // The clear is modelled as instantly wiping everything, since reads are
  // forced to zero for the whole sweep and the intermediate state is hidden.
  logic [DW-1:0] m1 [DEPTH];
  logic [DW-1:0] m0 [DEPTH];
  int busy_left = 0;

  typedef struct {
    bit            w;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(input bit zr, input logic [AW-1:0] a);
    if (!rst_n || busy_left > 0) return '0;
    if (zr && a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && a == waddr) return wdata;
`endif
    return zr ? m1[a] : m0[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m1[i] = '0;
      m0[i] = '0;
    end
    busy_left = 0;
  endtask

  task automatic model_step();
    if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (we) begin
        if (waddr != '0) m1[waddr] = wdata;
        m0[waddr] = wdata;
      end
      if (clr_req) begin
        for (int i = 0; i < DEPTH; i++) begin
          m1[i] = '0;
          m0[i] = '0;
        end
        busy_left = DEPTH;
      end
    end
  endtask

  task automatic drive(input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit c, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    we = w; waddr = wa; wdata = wd; clr_req = c; ra0 = a0; ra1 = a1;
  endtask

  task automatic check_outputs();
    chk("zr1_rd0", bus1.rdata[DW-1:0], ref_rd(1'b1, ra0));
    chk("zr1_rd1", bus1.rdata[2*DW-1:DW], ref_rd(1'b1, ra1));
    chk("zr0_rd0", bus0.rdata[DW-1:0], ref_rd(1'b0, ra0));
    chk("zr0_rd1", bus0.rdata[2*DW-1:DW], ref_rd(1'b0, ra1));
    chk("busy", {31'b0, bus1.busy}, {31'b0, busy_left > 0});
    chk("wr_rdy", {31'b0, bus1.wr_rdy}, {31'b0, (rst_n && busy_left == 0)});
    chk("zr0_busy", {31'b0, bus0.busy}, {31'b0, busy_left > 0});
  endtask

  task automatic sample();
    @(negedge clk);
    check_outputs();
    $display("cyc t=%0t we=%0b wa=%0d wd=%h clr=%0b ra={%0d,%0d} rd={%h,%h} busy=%0b rdy=%0b",
             $time, we, waddr, wdata, clr_req, ra0, ra1, bus1.rdata[DW-1:0],
             bus1.rdata[2*DW-1:DW], bus1.busy, bus1.wr_rdy);
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_cycle(input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input bit c, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    drive(w, wa, wd, c, a0, a1);
    sample();
    advance();
  endtask

  task automatic readback_all();
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(1'b0, '0, '0, 1'b0, AW'(i), AW'(DEPTH - 1 - i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    bit done;

    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0,        32'h0};
    tbl[1] = '{1'b1, 5'd31, 32'h12345678, 5'd1,  5'd2,  32'h0,        32'h0};
    tbl[2] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'hDEADBEEF, 32'h12345678};
    tbl[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    tbl[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd31, 32'h0,        32'h12345678};
    tbl[5] = '{1'b1, 5'd10, 32'h00000055, 5'd31, 5'd0,  32'h12345678, 32'h0};
    tbl[6] = '{1'b0, 5'd0,  32'h0,        5'd10, 5'd10, 32'h00000055, 32'h00000055};

    // Reset held for 3 cycles, outputs checked while in reset
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    readback_all();

    // Table-driven write/read and zero-register vectors
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].w, tbl[i].wa, tbl[i].wd, 1'b0, tbl[i].a0, tbl[i].a1);
      sample();
      chk("tbl_rd0", bus1.rdata[DW-1:0], tbl[i].e0);
      chk("tbl_rd1", bus1.rdata[2*DW-1:DW], tbl[i].e1);
      advance();
    end
    drive(1'b0, '0, '0, 1'b0, 5'd0, 5'd0);
    sample();
    chk("x0_plain", bus0.rdata[DW-1:0], 32'hFFFFFFFF);
    chk("x0_zero", bus1.rdata[DW-1:0], 32'h0);
    advance();

    // Bulk clear with a held write and a second clr_req mid-sweep
    for (int i = 1; i < DEPTH; i++) do_cycle(1'b1, AW'(i), DW'(i), 1'b0, AW'(i), 5'd0);
    do_cycle(1'b0, '0, '0, 1'b1, 5'd3, 5'd4);
    busy_cnt = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      drive(1'b1, 5'd7, 32'h000000AA, (cyc == 10), 5'd7, 5'd3);
      sample();
      if (bus1.busy) busy_cnt++;
      done = bus1.wr_rdy;
      advance();
    end
    chk("clr_exit", {31'b0, done}, 32'd1);
    chk("clr_len", DW'(busy_cnt), 32'd32);
    readback_all();
    drive(1'b0, '0, '0, 1'b0, 5'd7, 5'd8);
    sample();
    chk("x7_after", bus1.rdata[DW-1:0], 32'h000000AA);
    chk("x8_after", bus1.rdata[2*DW-1:DW], 32'h0);
    advance();

    // Reset asserted mid-sweep aborts it asynchronously
    for (int i = 1; i < DEPTH; i++) do_cycle(1'b1, AW'(i), ~DW'(i), 1'b0, 5'd0, 5'd0);
    do_cycle(1'b0, '0, '0, 1'b1, 5'd0, 5'd0);
    for (int i = 0; i < 10; i++) do_cycle(1'b0, '0, '0, 1'b0, 5'd1, 5'd31);
    drive(1'b0, '0, '0, 1'b0, 5'd20, 5'd31);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_busy", {31'b0, bus1.busy}, 32'd0);
    chk("rst_rdy", {31'b0, bus1.wr_rdy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    readback_all();

    // Same-cycle write/read to x9 and to x0
    do_cycle(1'b1, 5'd9, 32'h11111111, 1'b0, 5'd1, 5'd2);
    drive(1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 5'd9, 5'd0);
    sample();
`ifdef REGFILE_BYPASS_EN
    chk("byp_same", bus1.rdata[DW-1:0], 32'hCAFEF00D);
`else
    chk("byp_same", bus1.rdata[DW-1:0], 32'h11111111);
`endif
    advance();
    drive(1'b0, '0, '0, 1'b0, 5'd9, 5'd0);
    sample();
    chk("byp_next", bus1.rdata[DW-1:0], 32'hCAFEF00D);
    advance();
    drive(1'b1, 5'd0, 32'hCAFEF00D, 1'b0, 5'd0, 5'd9);
    sample();
    chk("byp_x0_same", bus1.rdata[DW-1:0], 32'h0);
    advance();
    drive(1'b0, '0, '0, 1'b0, 5'd0, 5'd9);
    sample();
    chk("byp_x0_next", bus1.rdata[DW-1:0], 32'h0);
    advance();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      do_cycle(($urandom_range(0, 2) != 0), AW'($urandom), DW'($urandom),
               ($urandom_range(0, 59) == 0), AW'($urandom), AW'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
